// File: rtl/flash_cmd_pkg.sv
// rtl/flash_cmd_pkg.sv - flash opcodes, decoder states and opcode classifiers; SPI_FAST_READ_EN adds 0x0B as a read
package flash_cmd_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_PP        = 8'h02;
    localparam logic [7:0] OP_SE        = 8'h20;
    localparam logic [7:0] OP_BE        = 8'hD8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_PASS
    } state_t;

    function automatic logic is_read_op(input logic [7:0] op);
`ifdef SPI_FAST_READ_EN
        return (op == OP_READ) || (op == OP_FAST_READ);
`else
        return (op == OP_READ);
`endif
    endfunction

    function automatic logic is_addr_op(input logic [7:0] op);
        return is_read_op(op) || (op == OP_PP) || (op == OP_SE) || (op == OP_BE);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizers for host sclk/cs_n/mosi with sclk-rise and cs_n-rise pulses
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic h_sclk,
    input  logic h_cs_n,
    input  logic h_mosi,
    output logic sclk_rise,
    output logic cs_rise,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_d;
    logic                   cs_d;

    // cs_n chain resets deasserted so a reset never looks like a transaction start
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_ff <= '0;
            cs_ff   <= '1;
            mosi_ff <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], h_sclk};
            cs_ff   <= {cs_ff[SYNC_STAGES-2:0], h_cs_n};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], h_mosi};
            sclk_d  <= sclk_ff[SYNC_STAGES-1];
            cs_d    <= cs_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_d;
    assign cs_rise   = cs_ff[SYNC_STAGES-1] & ~cs_d;
    assign cs_n_s    = cs_ff[SYNC_STAGES-1];
    assign mosi_s    = mosi_ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mosi_cmd_decoder.sv
// rtl/spi_mosi_cmd_decoder.sv - SPI MOSI snooper steering the MISO mux select; SPI_FAST_READ_EN decodes 0x0B as read
module spi_mosi_cmd_decoder
    import flash_cmd_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SF_BASE     = 24'h100000,
    parameter logic [ADDR_W-1:0] SF_LIMIT    = 24'h200000,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_sclk,
    input  logic              h_cs_n,
    input  logic              h_mosi,
    output logic              flash_select,
    output logic              cmd_valid,
    output logic [7:0]        cmd_opcode,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              busy
);

    logic              sclk_rise;
    logic              cs_rise;
    logic              cs_n_s;
    logic              mosi_s;
    state_t            state;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-2:0] shift_q;
    logic              sel_eval;
    logic              field_last;
    logic [7:0]        op_next;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .h_sclk    (h_sclk),
        .h_cs_n    (h_cs_n),
        .h_mosi    (h_mosi),
        .sclk_rise (sclk_rise),
        .cs_rise   (cs_rise),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s)
    );

    assign op_next    = {shift_q[6:0], mosi_s};
    assign field_last = sclk_rise && (((state == ST_CMD) && (bit_cnt == 5'd7)) ||
                                      ((state == ST_ADDR) && (bit_cnt == 5'd23)));

    always_ff @(posedge clk) begin
        cmd_valid  <= 1'b0;
        addr_valid <= 1'b0;
        sel_eval   <= 1'b0;
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            flash_select <= 1'b0;
            cmd_opcode   <= '0;
            cmd_addr     <= '0;
            busy         <= 1'b0;
        end else if (state == ST_IDLE) begin
            bit_cnt      <= '0;
            shift_q      <= '0;
            flash_select <= 1'b0;
            busy         <= 1'b0;
            if (!cs_n_s) begin
                state <= ST_CMD;
                busy  <= 1'b1;
            end
        end else if (cs_n_s && !(cs_rise && field_last)) begin
            // deselect aborts; a final bit landing with the cs_n rise finishes first
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            flash_select <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (sel_eval) begin
                flash_select <= is_read_op(cmd_opcode) && (cmd_addr >= SF_BASE) &&
                                (cmd_addr < SF_LIMIT);
            end
            if (sclk_rise) begin
                case (state)
                    ST_CMD: begin
                        if (bit_cnt == 5'd7) begin
                            cmd_opcode <= op_next;
                            cmd_valid  <= 1'b1;
                            bit_cnt    <= '0;
                            shift_q    <= '0;
                            state      <= is_addr_op(op_next) ? ST_ADDR : ST_PASS;
                        end else begin
                            shift_q <= {shift_q[ADDR_W-3:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    ST_ADDR: begin
                        if (bit_cnt == 5'd23) begin
                            cmd_addr   <= {shift_q, mosi_s};
                            addr_valid <= 1'b1;
                            sel_eval   <= 1'b1;
                            bit_cnt    <= '0;
                            shift_q    <= '0;
                            state      <= ST_PASS;
                        end else begin
                            shift_q <= {shift_q[ADDR_W-3:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mosi_cmd_decoder.sv
// tb/tb_spi_mosi_cmd_decoder.sv - directed table-driven bench for spi_mosi_cmd_decoder (SPI_FAST_READ_EN aware)
module tb_spi_mosi_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_sclk;
    logic        h_cs_n;
    logic        h_mosi;
    logic        flash_select;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic        addr_valid;
    logic [23:0] cmd_addr;
    logic        busy;

    spi_mosi_cmd_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .h_sclk       (h_sclk),
        .h_cs_n       (h_cs_n),
        .h_mosi       (h_mosi),
        .flash_select (flash_select),
        .cmd_valid    (cmd_valid),
        .cmd_opcode   (cmd_opcode),
        .addr_valid   (addr_valid),
        .cmd_addr     (cmd_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;
    int n_cmd = 0;
    int n_addr = 0;
    int addr_cyc = 0;
    int sel_cyc = 0;
    logic sel_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid) n_cmd = n_cmd + 1;
        if (addr_valid) begin
            n_addr   = n_addr + 1;
            addr_cyc = cyc;
        end
        if (flash_select && !sel_prev) sel_cyc = cyc;
        sel_prev = flash_select;
    end

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic        exp_av;
        logic        exp_sel;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        @(posedge clk); #1 h_mosi = b;
        repeat (3) @(posedge clk);
        #1 h_sclk = 1'b1;
        last_rise = cyc;
        repeat (4) @(posedge clk);
        #1 h_sclk = 1'b0;
    endtask

    task automatic spi_start(input logic [7:0] op, input logic [23:0] addr, input int nbits);
        @(posedge clk); #1 h_cs_n = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(op[i]);
        for (int i = 0; i < nbits; i++) spi_bit(addr[23-i]);
        repeat (3) @(posedge clk);
    endtask

    task automatic cs_release(input logic exp_sel);
        @(posedge clk); #1 h_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_before_drop", {31'd0, busy}, 32'd1);
        check("sel_held_pass", {31'd0, flash_select}, {31'd0, exp_sel});
        @(negedge clk);
        check("busy_drop_3clk", {31'd0, busy}, 32'd0);
        check("sel_idle", {31'd0, flash_select}, 32'd0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int c0;
        int a0;
        logic [23:0] prev_addr;

        vecs[0] = '{8'h03, 24'h0FFFFF, 1'b1, 1'b0};
        vecs[1] = '{8'h03, 24'h100000, 1'b1, 1'b1};
        vecs[2] = '{8'h03, 24'h1FFFFF, 1'b1, 1'b1};
        vecs[3] = '{8'h03, 24'h200000, 1'b1, 1'b0};
        vecs[4] = '{8'h02, 24'h150000, 1'b1, 1'b0};
        vecs[5] = '{8'hD8, 24'h180000, 1'b1, 1'b0};
        vecs[6] = '{8'h20, 24'h100000, 1'b1, 1'b0};
`ifdef SPI_FAST_READ_EN
        vecs[7] = '{8'h0B, 24'h180000, 1'b1, 1'b1};
`else
        vecs[7] = '{8'h0B, 24'h180000, 1'b0, 1'b0};
`endif
        vecs[8] = '{8'h9F, 24'hA5A5A5, 1'b0, 1'b0};

        rst = 1'b1; h_sclk = 1'b0; h_cs_n = 1'b1; h_mosi = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_flash_select", {31'd0, flash_select}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
        check("rst_cmd_opcode", {24'd0, cmd_opcode}, 32'd0);
        check("rst_cmd_addr", {8'd0, cmd_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // reset in the middle of the address field
        a0 = n_addr;
        spi_start(8'h03, 24'h150000, 12);
        check("midaddr_busy", {31'd0, busy}, 32'd1);
        check("midaddr_opcode", {24'd0, cmd_opcode}, 32'h03);
        @(posedge clk); #1 rst = 1'b1; h_cs_n = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_opcode", {24'd0, cmd_opcode}, 32'd0);
        check("midrst_addr", {8'd0, cmd_addr}, 32'd0);
        check("midrst_sel", {31'd0, flash_select}, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst_no_addr_valid", n_addr - a0, 0);

        for (int v = 0; v < 9; v++) begin
            c0 = n_cmd;
            a0 = n_addr;
            spi_start(vecs[v].op, vecs[v].addr, 24);
            @(negedge clk);
            check("cmd_valid_count", n_cmd - c0, 1);
            check("cmd_opcode", {24'd0, cmd_opcode}, {24'd0, vecs[v].op});
            check("addr_valid_count", n_addr - a0, {31'd0, vecs[v].exp_av});
            if (vecs[v].exp_av) begin
                check("cmd_addr", {8'd0, cmd_addr}, {8'd0, vecs[v].addr});
                check("addr_valid_latency", addr_cyc - last_rise, 3);
            end
            check("flash_select", {31'd0, flash_select}, {31'd0, vecs[v].exp_sel});
            if (vecs[v].exp_sel) check("select_latency", sel_cyc - last_rise, 4);
            cs_release(vecs[v].exp_sel);
        end

        // abort after 10 address bits of a read into the window
        prev_addr = cmd_addr;
        c0 = n_cmd;
        a0 = n_addr;
        spi_start(8'h03, 24'h180000, 10);
        cs_release(1'b0);
        @(negedge clk);
        check("abort_cmd_valid", n_cmd - c0, 1);
        check("abort_no_addr_valid", n_addr - a0, 0);
        check("abort_addr_kept", {8'd0, cmd_addr}, {8'd0, prev_addr});
        check("abort_opcode_kept", {24'd0, cmd_opcode}, 32'h03);
        check("abort_sel", {31'd0, flash_select}, 32'd0);

        // a normal read decodes correctly after the abort
        a0 = n_addr;
        spi_start(8'h03, 24'h123456, 24);
        @(negedge clk);
        check("post_abort_addr_valid", n_addr - a0, 1);
        check("post_abort_addr", {8'd0, cmd_addr}, 32'h123456);
        check("post_abort_sel", {31'd0, flash_select}, 32'd1);
        cs_release(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_mosi_cmd_decoder.md
Name: spi_mosi_cmd_decoder

Overview:
- Passively snoops the host SPI bus (mode 0, MSB first) on the host-to-flash path.
- Decodes the opcode and the 24-bit address of each transaction.
- Produces the registered flash_select that steers MISO back to the host: 0 = main flash, 1 = secondary flash.
- Sits beside the MISO mux and is the sole driver of its select input; also reports decoded commands to monitoring logic.

Parameters:
- SF_BASE, 24'h100000, first address served by the secondary flash (inclusive).
- SF_LIMIT, 24'h200000, end of the secondary window (exclusive). Legal only when SF_LIMIT > SF_BASE.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous host input (minimum 2).

Ports:
- clk  in  1  system clock; must run at least 4x h_sclk.
- rst  in  1  synchronous, active-high reset.
- h_sclk  in  1  host SPI clock (asynchronous to clk).
- h_cs_n  in  1  host chip select, active low (asynchronous).
- h_mosi  in  1  host MOSI (asynchronous).
- flash_select  out  1  0 = main, 1 = secondary; registered.
- cmd_valid  out  1  one-cycle pulse when the opcode byte is complete.
- cmd_opcode  out  8  last decoded opcode; held until the next cmd_valid.
- addr_valid  out  1  one-cycle pulse when the 24th address bit is captured.
- cmd_addr  out  24  last decoded address; held until the next addr_valid.
- busy  out  1  high while synchronized cs_n is low.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; shift register and bit counter cleared. Reset wins over every other event.
- Input conditioning: h_sclk, h_cs_n and h_mosi each pass through SYNC_STAGES flops. Rising-edge detect on synced sclk captures synced mosi into an 8-bit shift register (MSB first). Latency with SYNC_STAGES=2: bit captured 3 clk cycles after the raw h_sclk rise.
- Bit counter: 5 bits, reset to 0 on each byte/field boundary.
- States:
  - IDLE: wait for synced cs_n low → CMD, busy=1.
  - CMD: 8 bits. On the 8th bit: cmd_opcode updated and cmd_valid pulses in the same cycle. Address opcodes (0x03, 0x02, 0x20, 0xD8, plus 0x0B per the optional feature) → ADDR. All others → PASS.
  - ADDR: 24 bits shifted into cmd_addr staging. On the 24th bit: cmd_addr updated, addr_valid pulses. flash_select is registered 1 cycle later (4 clk after the last raw sclk rise). Next state PASS.
  - PASS: ignore sclk until cs_n rises.
- flash_select rule: 1 only when all of the following hold:
  - opcode is a read (0x03, or 0x0B when enabled), and
  - SF_BASE <= addr, and
  - addr < SF_LIMIT.
  Comparison is unsigned 24-bit. Writes and erases to any address give 0. flash_select holds through PASS.
- Synced cs_n rising in any non-IDLE state:
  - next cycle: state IDLE, flash_select=0, busy=0, bit counter cleared;
  - no pending addr_valid is emitted (aborted transaction);
  - cmd_opcode and cmd_addr keep their last values.
- cs_n rise on the same cycle as the 8th or 24th bit capture: the capture and its pulse complete, then IDLE the following cycle.
- sclk edges while cs_n is high are ignored.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined: 0x0B (fast read) is a read-with-address opcode. It enters ADDR and selects by window like 0x03. The dummy byte falls in PASS.
- Undefined: 0x0B is a non-address opcode. It goes CMD→PASS with no addr_valid and flash_select=0.

Decomposition:
- Package flash_cmd_pkg holds:
  - opcode localparams: OP_READ 8'h03, OP_FAST_READ 8'h0B, OP_PP 8'h02, OP_SE 8'h20, OP_BE 8'hD8;
  - state enum typedef;
  - ADDR_W=24.
- One sub-module, spi_in_sync: the SYNC_STAGES synchronizers for the three inputs plus the sclk rising-edge and cs_n rising-edge pulse generators.

Test Plan:
- Reset mid-ADDR: after 12 address bits, assert rst for 1 cycle → all outputs 0, state IDLE, no addr_valid. The next full transaction decodes normally.
- Read 0x03 to 0x0FFFFF → addr_valid with cmd_addr=0x0FFFFF, flash_select=0. Read to 0x100000 → flash_select=1, 4 clk after the last sclk rise. Read to 0x1FFFFF → 1. Read to 0x200000 → 0.
- Page program 0x02 to 0x150000 → cmd_valid with opcode 0x02, addr_valid with 0x150000, flash_select stays 0.
- Opcode 0x9F (JEDEC ID) followed by 24 extra clocks → cmd_valid only, no addr_valid, flash_select=0, busy drops 3 clk after the h_cs_n rise.
- Abort: cs_n rises after 10 address bits of 0x03 → no addr_valid, flash_select=0. cmd_addr keeps its previous value.
- 0x0B to 0x180000:
  - with SPI_FAST_READ_EN → addr_valid, flash_select=1;
  - without → no addr_valid, flash_select=0.
